// File: rtl/u_add_sub_arbiter.sv
// u_add_sub_arbiter: round-robin front end for one shared registered add/sub unit.
// Grants one requester per cycle and drives its operands to the unit. The unit
// result returns one cycle later and is queued, tagged with the requester index,
// in a 2-entry response FIFO with valid/ready backpressure.
module u_add_sub_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_add,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [WIDTH-1:0]         au_a,
  output logic [WIDTH-1:0]         au_b,
  output logic                     au_add,
  output logic                     au_cin,
  input  logic [WIDTH:0]           au_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH:0]           rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned OCC_W = 3;

  typedef struct packed {
    logic [WIDTH:0]  data;
    logic [ID_W-1:0] id;
  } rsp_t;

  // Unpacked views of the packed operand buses
  logic [WIDTH-1:0] op_a [NUM_REQ];
  logic [WIDTH-1:0] op_b [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_a[i] = req_a[i*WIDTH +: WIDTH];
    assign op_b[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Arbiter state
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  ptr_next;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  cand;
  logic             grant_found;

  // Issue tracking
  logic             inflight;
  logic [ID_W-1:0]  tag;
  logic             issue;
  logic             can_issue;
  logic [OCC_W-1:0] occ;

  // Response FIFO
  rsp_t             fifo_mem [DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;
  rsp_t             head;

  // Round-robin search starting at ptr, first valid requester wins
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  assign ptr_next = ID_W'((32'(grant) + 32'd1) % NUM_REQ);

  // Issue only while the in-flight slot plus FIFO can still absorb the result
  assign pop       = rsp_valid & rsp_ready;
  assign push      = inflight;
  assign occ       = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(pop);
  assign can_issue = (occ < OCC_W'(DEPTH));
  assign issue     = grant_found & can_issue & ~rst;

  // Grant handshake and operand steering to the unit; zero when idle
  always_comb begin
    req_ready = '0;
    au_a      = '0;
    au_b      = '0;
    au_add    = 1'b0;
    au_cin    = 1'b0;
    if (issue) begin
      req_ready = NUM_REQ'(1) << grant;
      au_a      = op_a[grant];
      au_b      = op_b[grant];
      au_add    = req_add[grant];
      au_cin    = req_cin[grant];
    end
  end

  // Round-robin pointer and in-flight slot
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag <= grant;
        ptr <= ptr_next;
      end
    end
  end

  // Response FIFO storage and occupancy; push captures the unit result
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{data: au_out, id: tag};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head of FIFO; outputs forced to zero while empty
  assign head      = fifo_mem[rd_ptr];
  assign rsp_valid = (fifo_count != '0);
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign rsp_id    = rsp_valid ? head.id : '0;
  assign busy      = inflight | (fifo_count != '0);

endmodule

// File: tb/tb_u_add_sub_arbiter.sv
// Directed self-checking bench for u_add_sub_arbiter with a behavioural add/sub unit.
module tb_u_add_sub_arbiter;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_add;
  logic [NUM_REQ-1:0]       req_cin;
  logic [WIDTH-1:0]         au_a;
  logic [WIDTH-1:0]         au_b;
  logic                     au_add;
  logic                     au_cin;
  logic [WIDTH:0]           au_out;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH:0]           rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  u_add_sub_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_add   (req_add),
    .req_cin   (req_cin),
    .au_a      (au_a),
    .au_b      (au_b),
    .au_add    (au_add),
    .au_cin    (au_cin),
    .au_out    (au_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Shared arithmetic unit: one registered stage, cin ignored on subtract
  always @(posedge clk) begin
    if (au_add) au_out <= {1'b0, au_a} + {1'b0, au_b} + {{WIDTH{1'b0}}, au_cin};
    else        au_out <= {1'b0, au_a} - {1'b0, au_b};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then check the outstanding-work bound
  task automatic tick();
    int occ;
    @(posedge clk);
    #2;
    occ = int'(dut.fifo_count) + int'(dut.inflight);
    checks++;
    assert (occ <= 2) else begin
      errors++;
      $error("FAIL occupancy: observed=%0d expected<=2", occ);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic add, input logic cin);
    req_valid[i]             = v;
    req_a[i*WIDTH +: WIDTH]  = a;
    req_b[i*WIDTH +: WIDTH]  = b;
    req_add[i]               = add;
    req_cin[i]               = cin;
  endtask

  initial begin
    int exp_g [6];
    exp_g = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1; rsp_ready = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_add = '0; req_cin = '0;
    tick(); tick();
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data",  64'(rsp_data),  64'd0);
    chk("rst_rsp_id",    64'(rsp_id),    64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_au_a",      64'(au_a),      64'd0);
    rst = 1'b0;
    tick();

    // Single add with carry out
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
    #1;
    chk("add_ready",  64'(req_ready), 64'b0001);
    chk("add_au_a",   64'(au_a),      64'hFFFF_FFFF);
    chk("add_au_b",   64'(au_b),      64'd1);
    chk("add_au_ctl", 64'({au_add, au_cin}), 64'b11);
    tick();
    req_valid = '0;
    #1;
    chk("add_lat1_valid", 64'(rsp_valid), 64'd0);
    chk("add_lat1_busy",  64'(busy),      64'd1);
    tick();
    chk("add_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("add_rsp_data",  64'(rsp_data),  64'h1_0000_0001);
    chk("add_rsp_id",    64'(rsp_id),    64'd0);
    tick();
    chk("add_drain_valid", 64'(rsp_valid), 64'd0);
    chk("add_drain_busy",  64'(busy),      64'd0);
    chk("add_ptr",         64'(dut.ptr),   64'd1);

    // Sparse: only req3 with ptr=1, then req1 alone
    set_req(3, 1'b1, 32'd10, 32'd20, 1'b1, 1'b0);
    #1;
    chk("sparse3_ready", 64'(req_ready), 64'b1000);
    tick();
    chk("sparse_ptr", 64'(dut.ptr), 64'd0);
    req_valid = '0;
    set_req(1, 1'b1, 32'd7, 32'd2, 1'b0, 1'b0);
    #1;
    chk("sparse1_ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    #1;
    chk("sparse3_rsp_data", 64'(rsp_data), 64'd30);
    chk("sparse3_rsp_id",   64'(rsp_id),   64'd3);
    tick();
    chk("sparse1_rsp_data", 64'(rsp_data), 64'd5);
    chk("sparse1_rsp_id",   64'(rsp_id),   64'd1);
    tick();
    chk("sparse_drain", 64'(rsp_valid), 64'd0);

    // Subtract with borrow, cin ignored
    set_req(2, 1'b1, 32'd3, 32'd5, 1'b0, 1'b1);
    #1;
    chk("sub_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    tick();
    chk("sub_rsp_data", 64'(rsp_data), 64'h1_FFFF_FFFE);
    chk("sub_rsp_id",   64'(rsp_id),   64'd2);
    tick();
    chk("sub_drain", 64'(rsp_valid), 64'd0);

    // Reset with one result buffered and one in flight
    rsp_ready = 1'b0;
    set_req(3, 1'b1, 32'd1, 32'd1, 1'b1, 1'b0);
    #1;
    chk("rstmid_ready3", 64'(req_ready), 64'b1000);
    tick();
    req_valid = '0;
    set_req(1, 1'b1, 32'd9, 32'd9, 1'b1, 1'b0);
    #1;
    chk("rstmid_ready1", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    #1;
    chk("rstmid_head_valid", 64'(rsp_valid), 64'd1);
    chk("rstmid_head_data",  64'(rsp_data),  64'd2);
    chk("rstmid_head_id",    64'(rsp_id),    64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("rstmid_valid", 64'(rsp_valid), 64'd0);
    chk("rstmid_busy",  64'(busy),      64'd0);
    chk("rstmid_ptr",   64'(dut.ptr),   64'd0);
    chk("rstmid_data",  64'(rsp_data),  64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstmid_no_stale", 64'(rsp_valid), 64'd0);
    end

    // Round robin: all four valid, result = 100 + 2*i
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'(100 + i), 32'(i), 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_grant", 64'(req_ready), 64'(1) << exp_g[k]);
      if (k >= 2) begin
        chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rr_rsp_id",    64'(rsp_id),    64'(exp_g[k-2]));
        chk("rr_rsp_data",  64'(rsp_data),  64'(100 + 2 * exp_g[k-2]));
      end
      tick();
    end
    req_valid = '0;
    #1;
    chk("rr_tail0_id",   64'(rsp_id),   64'd0);
    chk("rr_tail0_data", 64'(rsp_data), 64'd100);
    tick();
    chk("rr_tail1_id",   64'(rsp_id),   64'd1);
    chk("rr_tail1_data", 64'(rsp_data), 64'd102);
    tick();
    chk("rr_drain", 64'(rsp_valid), 64'd0);

    // Backpressure: two accepts, then stall until the first pop
    rsp_ready = 1'b0;
    req_valid = '1;
    #1;
    chk("bp_grant2", 64'(req_ready), 64'b0100);
    tick();
    chk("bp_grant3", 64'(req_ready), 64'b1000);
    tick();
    chk("bp_stall_ready", 64'(req_ready), 64'd0);
    chk("bp_stall_busy",  64'(busy),      64'd1);
    tick();
    chk("bp_full_ready", 64'(req_ready), 64'd0);
    chk("bp_head_id",    64'(rsp_id),    64'd2);
    chk("bp_head_data",  64'(rsp_data),  64'd104);
    tick();
    chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
    chk("bp_hold_id",    64'(rsp_id),    64'd2);
    chk("bp_hold_data",  64'(rsp_data),  64'd104);
    chk("bp_hold_ready", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    #1;
    chk("bp_rsp2_id",   64'(rsp_id),   64'd3);
    chk("bp_rsp2_data", 64'(rsp_data), 64'd106);
    tick();
    chk("bp_rsp3_id",   64'(rsp_id),   64'd0);
    chk("bp_rsp3_data", 64'(rsp_data), 64'd100);
    tick();
    chk("bp_drain_valid", 64'(rsp_valid), 64'd0);
    chk("bp_drain_busy",  64'(busy),      64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
